// File: rtl/fp_align_pkg.sv
// Shared widths, operand/stage typedefs and width helper for the FP operand-alignment stage.
// Types here are the default-width views; the pipeline re-declares them at its parameter widths.
package fp_align_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int GRS_W_DEF = 3;

    // Significand width: hidden bit + stored mantissa + guard/round/sticky.
    function automatic int sig_w(input int man_w, input int grs_w);
        return man_w + 1 + grs_w;
    endfunction

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF-1:0] man;
    } fp_op_t;

    typedef struct packed {
        logic                           sign_a;
        logic                           sign_b;
        logic [EXP_W_DEF-1:0]           exp;
        logic [EXP_W_DEF:0]             diff;
        logic                           swap;
        logic                           special;
        logic [MAN_W_DEF+GRS_W_DEF:0]   sig_a;
        logic [MAN_W_DEF+GRS_W_DEF:0]   sig_b;
    } s1_t;

endpackage

// File: rtl/fp_align_shift.sv
// Combinational right barrel shifter; shifted-out bits fold into bit 0 as sticky,
// and any shift of W or more collapses the operand to a single sticky bit.
module fp_align_shift #(
    parameter int W    = 27,
    parameter int SH_W = 9
) (
    input  logic [W-1:0]    sig_in,
    input  logic [SH_W-1:0] amount,
    output logic [W-1:0]    sig_out
);

    logic [W-1:0] lost_mask;

    always_comb begin
        lost_mask = ~({W{1'b1}} << amount);
        if (32'(amount) >= W)
            sig_out = {{(W-1){1'b0}}, |sig_in};
        else
            sig_out = (sig_in >> amount) | {{(W-1){1'b0}}, |(sig_in & lost_mask)};
    end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage operand alignment for the FP adder: S1 unpacks/compares, S2 shifts the smaller operand.
// Define FPALIGN_DENORM_EN to treat a zero exponent as a denormal (hidden bit 0, effective exponent 1).
module fp_align_pipe
    import fp_align_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int GRS_W = GRS_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign_a,
    output logic                   out_sign_b,
    output logic [EXP_W-1:0]       out_exp,
    output logic [MAN_W+GRS_W:0]   out_man_a,
    output logic [MAN_W+GRS_W:0]   out_man_b,
    output logic                   out_swap,
    output logic                   out_special
);

    localparam int SIG_W  = sig_w(MAN_W, GRS_W);
    localparam int STAGES = 2;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } op_t;

    typedef struct packed {
        logic             sign_a;
        logic             sign_b;
        logic [EXP_W-1:0] exp;
        logic [EXP_W:0]   diff;
        logic             swap;
        logic             special;
        logic [SIG_W-1:0] sig_a;
        logic [SIG_W-1:0] sig_b;
    } stage1_t;

    op_t              op_a, op_b;
    logic             hid_a, hid_b;
    logic [EXP_W:0]   eff_a, eff_b;
    stage1_t          s1_nxt, s1;
    logic [STAGES:1]  vld_pipe;
    logic             s1_rdy, s2_rdy;
    logic [SIG_W-1:0] shift_in, shift_out;

    assign op_a = op_t'(in_a);
    assign op_b = op_t'(in_b);

`ifdef FPALIGN_DENORM_EN
    assign hid_a = |op_a.exp;
    assign hid_b = |op_b.exp;
    assign eff_a = hid_a ? {1'b0, op_a.exp} : (EXP_W+1)'(1);
    assign eff_b = hid_b ? {1'b0, op_b.exp} : (EXP_W+1)'(1);
`else
    assign hid_a = 1'b1;
    assign hid_b = 1'b1;
    assign eff_a = {1'b0, op_a.exp};
    assign eff_b = {1'b0, op_b.exp};
`endif

    always_comb begin
        s1_nxt         = '0;
        s1_nxt.sign_a  = op_a.sign;
        s1_nxt.sign_b  = op_b.sign;
        s1_nxt.special = (&op_a.exp) | (&op_b.exp);
        s1_nxt.sig_a   = {hid_a, op_a.man, {GRS_W{1'b0}}};
        s1_nxt.sig_b   = {hid_b, op_b.man, {GRS_W{1'b0}}};
        // Ties keep A as the reference operand.
        s1_nxt.swap    = eff_b > eff_a;
        s1_nxt.diff    = s1_nxt.swap ? (eff_b - eff_a) : (eff_a - eff_b);
        s1_nxt.exp     = s1_nxt.swap ? eff_b[EXP_W-1:0] : eff_a[EXP_W-1:0];
    end

    assign s2_rdy    = !vld_pipe[2] || out_ready;
    assign s1_rdy    = !vld_pipe[1] || s2_rdy;
    assign in_ready  = s1_rdy;
    assign out_valid = vld_pipe[2];

    assign shift_in = s1.swap ? s1.sig_a : s1.sig_b;

    fp_align_shift #(.W(SIG_W), .SH_W(EXP_W+1)) u_shift (
        .sig_in  (shift_in),
        .amount  (s1.diff),
        .sig_out (shift_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe    <= '0;
            s1          <= '0;
            out_sign_a  <= 1'b0;
            out_sign_b  <= 1'b0;
            out_exp     <= '0;
            out_man_a   <= '0;
            out_man_b   <= '0;
            out_swap    <= 1'b0;
            out_special <= 1'b0;
        end else begin
            if (s1_rdy) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1 <= s1_nxt;
            end
            if (s2_rdy) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_sign_a  <= s1.sign_a;
                    out_sign_b  <= s1.sign_b;
                    out_exp     <= s1.exp;
                    out_man_a   <= s1.swap ? shift_out : s1.sig_a;
                    out_man_b   <= s1.swap ? s1.sig_b : shift_out;
                    out_swap    <= s1.swap;
                    out_special <= s1.special;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe: arithmetic reference model + scoreboard,
// directed literal vectors, stall/reset scenarios and a random-traffic phase.
module tb_fp_align_pipe;
    import fp_align_pkg::*;

    localparam int SW = 27;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign_a, out_sign_b, out_swap, out_special;
    logic [7:0]  out_exp;
    logic [26:0] out_man_a, out_man_b;

    int checks = 0;
    int errors = 0;
    int emitted = 0;

    typedef struct {
        logic        sa, sb;
        logic [7:0]  e;
        logic [26:0] ma, mb;
        logic        sw, sp;
    } exp_t;

    exp_t q[$];

    fp_align_pipe dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign_a(out_sign_a), .out_sign_b(out_sign_b), .out_exp(out_exp),
        .out_man_a(out_man_a), .out_man_b(out_man_b),
        .out_swap(out_swap), .out_special(out_special)
    );

    always #5 clock = ~clock;

    // Right shift by d expressed as integer division; any remainder sets the LSB.
    function automatic logic [26:0] shr(input longint s, input int d);
        longint p, v;
        if (d >= SW) return (s != 0) ? 27'd1 : 27'd0;
        p = longint'(1) << d;
        v = s / p;
        if ((s % p) != 0) v = v | 1;
        return 27'(v);
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        fp_op_t oa, ob;
        int     ea, eb, ha, hb;
        longint siga, sigb;
        exp_t   m;
        oa = fp_op_t'(a);
        ob = fp_op_t'(b);
        ea = int'(oa.exp);
        eb = int'(ob.exp);
        ha = 1;
        hb = 1;
`ifdef FPALIGN_DENORM_EN
        if (ea == 0) begin ea = 1; ha = 0; end
        if (eb == 0) begin eb = 1; hb = 0; end
`endif
        siga = (longint'(ha) * 8388608 + longint'(oa.man)) * 8;
        sigb = (longint'(hb) * 8388608 + longint'(ob.man)) * 8;
        m.sa = oa.sign;
        m.sb = ob.sign;
        m.sp = (oa.exp == 8'hFF) || (ob.exp == 8'hFF);
        if (eb > ea) begin
            m.e = 8'(eb); m.sw = 1'b1; m.mb = 27'(sigb); m.ma = shr(siga, eb - ea);
        end else begin
            m.e = 8'(ea); m.sw = 1'b0; m.ma = 27'(siga); m.mb = shr(sigb, ea - eb);
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Scoreboard bookkeeping at the clock edge (inputs are stable here).
    always @(posedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                emitted++;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(in_a, in_b));
        end
    end

    // Every cycle with a valid output is compared against the oldest expectation.
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_output: got valid exp=%h ma=%h mb=%h required no output",
                         out_exp, out_man_a, out_man_b);
            end else if ({out_sign_a, out_sign_b, out_exp, out_man_a, out_man_b, out_swap, out_special} !==
                         {q[0].sa, q[0].sb, q[0].e, q[0].ma, q[0].mb, q[0].sw, q[0].sp}) begin
                errors++;
                $display("FAIL scoreboard: got sa=%b sb=%b e=%h ma=%h mb=%h sw=%b sp=%b required sa=%b sb=%b e=%h ma=%h mb=%h sw=%b sp=%b",
                         out_sign_a, out_sign_b, out_exp, out_man_a, out_man_b, out_swap, out_special,
                         q[0].sa, q[0].sb, q[0].e, q[0].ma, q[0].mb, q[0].sw, q[0].sp);
            end
        end
    end

    // Present one pair (called just after a posedge); returns right after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        logic acc;
        #1;
        in_a = a; in_b = b; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send1(input logic [31:0] a, input logic [31:0] b);
        send(a, b);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = out_valid;
        end
        if (!seen) chk("out_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clock);
        @(negedge clock);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_zero(input string name);
        chk(name, {out_valid, out_sign_a, out_sign_b, out_exp, out_man_a, out_man_b, out_swap, out_special}, 64'd0);
    endtask

    logic [26:0] held_a, held_b;
    int          base;

    initial begin
        // Reset state
        #12;
        chk_zero("reset_outputs");
        @(negedge clock);
        reset = 1'b0;
        #1 chk("reset_in_ready", 64'(in_ready), 64'd1);

        // 1: B shifted by one, latency 2
        @(posedge clock);
        send1(32'h40400000, 32'h3F800000);
        @(negedge clock);
        chk("t1_not_yet_valid", 64'(out_valid), 64'd0);
        @(negedge clock);
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        chk("t1_exp", 64'(out_exp), 64'h80);
        chk("t1_man_a", 64'(out_man_a), 64'h6000000);
        chk("t1_man_b", 64'(out_man_b), 64'h2000000);
        chk("t1_swap", 64'(out_swap), 64'd0);
        drain();

        // 2: A shifted by 23 with sticky
        @(posedge clock);
        send1(32'h3F800001, 32'h4B000000);
        wait_out();
        chk("t2_exp", 64'(out_exp), 64'h96);
        chk("t2_man_a", 64'(out_man_a), 64'h0000009);
        chk("t2_man_b", 64'(out_man_b), 64'h4000000);
        chk("t2_swap", 64'(out_swap), 64'd1);
        drain();

        // 3: saturating shift
        @(posedge clock);
        send1(32'h7F000000, 32'h00800000);
        wait_out();
        chk("t3_exp", 64'(out_exp), 64'hFE);
        chk("t3_man_b", 64'(out_man_b), 64'h0000001);
        chk("t3_special", 64'(out_special), 64'd0);
        drain();

        // Special flag from raw exponent, alignment unchanged
        @(posedge clock);
        send1(32'hFF800000, 32'h3F800000);
        wait_out();
        chk("tsp_special", 64'(out_special), 64'd1);
        chk("tsp_sign_a", 64'(out_sign_a), 64'd1);
        chk("tsp_man_b", 64'(out_man_b), 64'h0000001);
        drain();

        // 6: zero exponent operand
        @(posedge clock);
        send1(32'h00400000, 32'h00800000);
        wait_out();
        chk("t6_exp", 64'(out_exp), 64'h01);
`ifdef FPALIGN_DENORM_EN
        chk("t6_man_a", 64'(out_man_a), 64'h2000000);
        chk("t6_swap", 64'(out_swap), 64'd0);
`else
        chk("t6_man_a", 64'(out_man_a), 64'h3000000);
        chk("t6_swap", 64'(out_swap), 64'd1);
`endif
        drain();

        // 4: back-to-back with a downstream stall
        base = emitted;
        @(posedge clock);
        #1 out_ready = 1'b0;
        send(32'h40000000, 32'h3F800000);
        send(32'h41200000, 32'hC0A00000);
        #1 in_a = 32'h3F000000; in_b = 32'h3E800000;
        @(negedge clock);
        chk("t4_in_ready_low", 64'(in_ready), 64'd0);
        held_a = out_man_a;
        held_b = out_man_b;
        repeat (2) begin
            @(negedge clock);
            chk("t4_in_ready_held", 64'(in_ready), 64'd0);
            chk("t4_stable", {out_man_a, out_man_b}, {held_a, held_b});
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        chk("t4_in_ready_back", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        drain();
        chk("t4_emitted", 64'(emitted - base), 64'd3);

        // 5: reset with both stages full
        @(posedge clock);
        #1 out_ready = 1'b0;
        send(32'h40400000, 32'h3F800000);
        send(32'h3F800001, 32'h4B000000);
        #1 in_valid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1 chk_zero("t5_reset_drop");
        q.delete();
        base = emitted;
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clock);
            chk("t5_nothing_out", 64'(out_valid), 64'd0);
        end
        chk("t5_emitted", 64'(emitted - base), 64'd0);

        // Random traffic with random downstream backpressure
        begin
            logic acc;
            int   ea, eb;
            acc = 1'b0;
            @(posedge clock);
            for (int i = 0; i < 3000; i++) begin
                #1;
                out_ready = ($urandom % 4) != 0;
                if (acc || !in_valid) begin
                    ea = int'($urandom_range(0, 255));
                    case ($urandom % 4)
                        0: eb = ea;
                        1: eb = int'($urandom_range(0, 255));
                        default: eb = ea + int'($urandom_range(0, 60)) - 30;
                    endcase
                    if (eb < 0) eb = 0;
                    if (eb > 255) eb = 255;
                    in_valid = ($urandom % 4) != 0;
                    in_a = {1'($urandom), 8'(ea), 23'($urandom)};
                    in_b = {1'($urandom), 8'(eb), 23'($urandom)};
                end
                @(negedge clock);
                acc = in_valid && in_ready;
                @(posedge clock);
            end
            #1 in_valid = 1'b0;
            out_ready = 1'b1;
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
